// File: rtl/x_div_ctrl_pkg.sv
// Shared constants, state encoding and sign helper for the multi-cycle signed divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package x_div_ctrl_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_ITERS = DIV_W;

  localparam logic [DIV_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Two's-complement negate when n is set. Used for both the operand
  // magnitude (|INT_MIN| stays 0x80000000, read as unsigned) and the
  // final quotient sign fix.
  function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v,
                                               input logic             n);
    return n ? (~v + DIV_W'(1)) : v;
  endfunction

endpackage

// File: rtl/x_div_ctrl_if.sv
// Operand/result bundle between the processor multdiv unit and the divider.
// Latency: n/a (wires only).
// Backpressure: none; ctrl_DIV is a start pulse, data_resultRDY a one-cycle completion pulse.
//
// Signals: ctrl_DIV (start), data_operandA (dividend), data_operandB (divisor),
//          data_result (quotient), data_exception, data_resultRDY, busy.
interface x_div_ctrl_if
  import x_div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_W
);

  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/x_div_step.sv
// One restoring division step: compare/subtract the divisor against the shifted partial's upper half.
// Latency: combinational.
// Backpressure: none.
//
// Ports: divisor      - unsigned divisor magnitude
//        partial_shl  - partial remainder/quotient register already shifted left by one
//        partial_nxt  - partial after the conditional subtract and quotient bit insert
module x_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   divisor,
  input  logic [2*WIDTH-1:0] partial_shl,
  output logic [2*WIDTH-1:0] partial_nxt
);

  logic [WIDTH:0] diff;

  // Compare is done one bit wider than the operands: the divisor magnitude
  // can be 0x80000000, so the upper half's top bit alone cannot be trusted
  // as a "negative result" flag.
  always_comb begin
    diff        = {1'b0, partial_shl[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    partial_nxt = partial_shl;
    if (!diff[WIDTH]) begin
      partial_nxt[2*WIDTH-1:WIDTH] = diff[WIDTH-1:0];
      partial_nxt[0]               = 1'b1;
    end
  end

endmodule

// File: rtl/x_div_ctrl.sv
// Signed 32-bit multi-cycle restoring divider controller (quotient truncated toward zero).
// Latency: fixed; ctrl_DIV sampled at edge E0 -> data_resultRDY high in the cycle after edge E0+34.
// Backpressure: none; a new ctrl_DIV at any time aborts and restarts, the aborted op never reports.
//
// Ports: clock, reset (sync, active-high)
//        bus.slave: ctrl_DIV, data_operandA/B in; data_result, data_exception,
//                   data_resultRDY, busy out.
module x_div_ctrl
  import x_div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input logic        clock,
  input logic        reset,
  x_div_ctrl_if.slave bus
);

  localparam int CW = $clog2(DIV_ITERS);

  div_state_e         state;
  div_state_e         state_nxt;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] partial_shl;
  logic [2*WIDTH-1:0] partial_step;
  logic [WIDTH-1:0]   divisor_reg;
  logic               sign_a;
  logic               sign_b;
  logic               divzero;
  logic               ovf;

  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;
  logic               busy_q;

  logic               start;
  logic               last_step;

  assign start     = bus.ctrl_DIV;
  assign last_step = (count == CW'(DIV_ITERS - 1));

  assign partial_shl = partial << 1;

  x_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .divisor     (divisor_reg),
    .partial_shl (partial_shl),
    .partial_nxt (partial_step)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a start pulse restarts from any state.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_RUN:  if (last_step) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      partial     <= '0;
      divisor_reg <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      divzero     <= 1'b0;
      ovf         <= 1'b0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        sign_a      <= bus.data_operandA[WIDTH-1];
        sign_b      <= bus.data_operandB[WIDTH-1];
        divzero     <= (bus.data_operandB == '0);
        ovf         <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
        partial     <= {{WIDTH{1'b0}}, neg_if(bus.data_operandA, bus.data_operandA[WIDTH-1])};
        divisor_reg <= neg_if(bus.data_operandB, bus.data_operandB[WIDTH-1]);
        count       <= '0;
        busy_q      <= 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            partial <= partial_step;
            count   <= count + CW'(1);
          end
          ST_FIX: begin
            // Exceptions are resolved here rather than at start so the
            // latency stays fixed regardless of operands.
            if (divzero) begin
              result_q <= '0;
              exc_q    <= 1'b1;
            end else if (ovf) begin
              result_q <= INT_MIN;
              exc_q    <= 1'b1;
            end else begin
              result_q <= neg_if(partial[WIDTH-1:0], sign_a ^ sign_b);
              exc_q    <= 1'b0;
            end
          end
          ST_DONE: begin
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule
